match_sequencer: RTL and testbench

Top-level game sequencer for the pong datapath. It owns the 2-bit game `state` consumed by the score counter, ball and paddle logic, and the display. It detects ball-out events on frame ticks and issues one-cycle point pulses. It times the post-point pause, decides match end from the score counter's outputs, and selects serve direction.

---
 rtl/match_sequencer.sv | 147 ++++++++++++++
 tb/tb_match_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : match_sequencer                                              |
// | Description : Pong game sequencer - detects points and times the pause.    |
// |               It also decides the winner and picks the serve direction.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module match_sequencer #(
    parameter int X_PAD_L     = 30,
    parameter int X_PAD_R     = 979,
    parameter int BALL_SIZE   = 15,
    parameter int WIN_SCORE   = 9,
    parameter int PAUSE_TICKS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        start_btn,
    input  logic [10:0] x_ball,
    input  logic [3:0]  player1_score,
    input  logic [3:0]  player2_score,
    output logic [1:0]  state,
    output logic        p1_point,
    output logic        p2_point,
    output logic        ball_reset,
    output logic        serve_dir,
    output logic [1:0]  winner
);

    localparam logic [1:0] c_MENU_START  = 2'b00;
    localparam logic [1:0] c_GAME_PLAY   = 2'b01;
    localparam logic [1:0] c_POINT_PAUSE = 2'b10;
    localparam logic [1:0] c_GAME_OVER   = 2'b11;

    localparam int                  c_CNT_W    = $clog2(PAUSE_TICKS + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(PAUSE_TICKS - 1);
    localparam logic [10:0]         c_X_LEFT   = 11'(X_PAD_L);
    localparam logic [10:0]         c_X_RIGHT  = 11'(X_PAD_R - BALL_SIZE / 2);
    localparam logic [3:0]          c_WIN      = 4'(WIN_SCORE);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_pause_cnt;
    logic               r_start_prev;
    logic               r_p1_point;
    logic               r_p2_point;
    logic               r_serve_dir;
    logic [1:0]         r_winner;

    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] w_pause_cnt_next;
    logic               w_p1_point_next;
    logic               w_p2_point_next;
    logic               w_serve_dir_next;
    logic [1:0]         w_winner_next;
    logic               w_start_edge;

    assign w_start_edge = start_btn & ~r_start_prev;

    // start_prev resets high so a button held through reset cannot start a game
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_MENU_START;
            r_pause_cnt  <= '0;
            r_start_prev <= 1'b1;
            r_p1_point   <= 1'b0;
            r_p2_point   <= 1'b0;
            r_serve_dir  <= 1'b1;
            r_winner     <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_pause_cnt  <= w_pause_cnt_next;
            r_start_prev <= start_btn;
            r_p1_point   <= w_p1_point_next;
            r_p2_point   <= w_p2_point_next;
            r_serve_dir  <= w_serve_dir_next;
            r_winner     <= w_winner_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pause_cnt_next = r_pause_cnt;
        w_p1_point_next  = 1'b0;
        w_p2_point_next  = 1'b0;
        w_serve_dir_next = r_serve_dir;
        w_winner_next    = r_winner;
        case (r_state)
            c_MENU_START: begin
                w_pause_cnt_next = '0;
                w_winner_next    = 2'b00;
                if (w_start_edge) begin
                    w_state_next     = c_GAME_PLAY;
                    w_serve_dir_next = 1'b1;
                end
            end
            c_GAME_PLAY: begin
                // Serve goes toward whoever conceded; left goal wins a tie
                if (timing_tick) begin
                    if (x_ball < c_X_LEFT) begin
                        w_p2_point_next  = 1'b1;
                        w_serve_dir_next = 1'b0;
                        w_state_next     = c_POINT_PAUSE;
                    end else if (x_ball > c_X_RIGHT) begin
                        w_p1_point_next  = 1'b1;
                        w_serve_dir_next = 1'b1;
                        w_state_next     = c_POINT_PAUSE;
                    end
                end
            end
            c_POINT_PAUSE: begin
                if (timing_tick) begin
                    if (r_pause_cnt == c_CNT_LAST) begin
                        w_pause_cnt_next = '0;
                        if (player1_score >= c_WIN) begin
                            w_winner_next = 2'b01;
                            w_state_next  = c_GAME_OVER;
                        end else if (player2_score >= c_WIN) begin
                            w_winner_next = 2'b10;
                            w_state_next  = c_GAME_OVER;
                        end else begin
                            w_state_next  = c_GAME_PLAY;
                        end
                    end else begin
                        w_pause_cnt_next = r_pause_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (w_start_edge) begin
                    w_state_next  = c_MENU_START;
                    w_winner_next = 2'b00;
                end
            end
        endcase
    end

    always_comb begin
        state      = r_state;
        p1_point   = r_p1_point;
        p2_point   = r_p2_point;
        serve_dir  = r_serve_dir;
        winner     = r_winner;
        ball_reset = (r_state != c_GAME_PLAY);
    end

endmodule
`default_nettype wire

// File: tb/tb_match_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_match_sequencer                                           |
// | Description : Self-checking bench for match_sequencer (event-level model). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_match_sequencer;

    localparam int PAUSE_TICKS = 60;
    localparam int LEFT_GOAL   = 30;
    localparam int RIGHT_GOAL  = 972;
    localparam int WIN_SCORE   = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        timing_tick;
    logic        start_btn;
    logic [10:0] x_ball;
    logic [3:0]  player1_score;
    logic [3:0]  player2_score;
    logic [1:0]  state;
    logic        p1_point;
    logic        p2_point;
    logic        ball_reset;
    logic        serve_dir;
    logic [1:0]  winner;

    int n_checks = 0;
    int n_fail   = 0;

    match_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .timing_tick   (timing_tick),
        .start_btn     (start_btn),
        .x_ball        (x_ball),
        .player1_score (player1_score),
        .player2_score (player2_score),
        .state         (state),
        .p1_point      (p1_point),
        .p2_point      (p2_point),
        .ball_reset    (ball_reset),
        .serve_dir     (serve_dir),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Event-level model: phase number, ticks left in the pause, last button level
    int m_phase  = 0;
    int m_p1     = 0;
    int m_p2     = 0;
    int m_serve  = 1;
    int m_winner = 0;
    int m_left   = 0;
    bit m_prev   = 1'b1;
    bit m_press;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_p1 = 0; m_p2 = 0; m_serve = 1; m_winner = 0; m_prev = 1'b1;
        end else begin
            m_press = start_btn && !m_prev;
            m_prev  = start_btn;
            m_p1 = 0;
            m_p2 = 0;
            case (m_phase)
                0: begin
                    m_winner = 0;
                    if (m_press) begin m_phase = 1; m_serve = 1; end
                end
                1: if (timing_tick) begin
                    if (int'(x_ball) < LEFT_GOAL) begin
                        m_p2 = 1; m_serve = 0; m_phase = 2; m_left = PAUSE_TICKS;
                    end else if (int'(x_ball) > RIGHT_GOAL) begin
                        m_p1 = 1; m_serve = 1; m_phase = 2; m_left = PAUSE_TICKS;
                    end
                end
                2: if (timing_tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (int'(player1_score) >= WIN_SCORE)      begin m_winner = 1; m_phase = 3; end
                        else if (int'(player2_score) >= WIN_SCORE) begin m_winner = 2; m_phase = 3; end
                        else m_phase = 1;
                    end
                end
                default: if (m_press) begin m_phase = 0; m_winner = 0; end
            endcase
        end
        #1;
        chk("state", int'(state), m_phase);
        chk("p1_point", int'(p1_point), m_p1);
        chk("p2_point", int'(p2_point), m_p2);
        chk("serve_dir", int'(serve_dir), m_serve);
        chk("winner", int'(winner), m_winner);
        chk("ball_reset", int'(ball_reset), (m_phase != 1) ? 1 : 0);
        chk("points_exclusive", int'(p1_point & p2_point), 0);
    end

    task automatic cyc(input bit tick, input int x, input bit btn);
        @(negedge clk);
        timing_tick = tick;
        x_ball      = 11'(x);
        start_btn   = btn;
        @(posedge clk);
        #2;
    endtask

    task automatic pause_ticks(input int n);
        repeat (n) begin
            cyc(1'b1, 500, start_btn);
            cyc(1'b0, 500, start_btn);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; timing_tick = 1'b0; start_btn = 1'b1; x_ball = 11'd500;
        player1_score = 4'd0; player2_score = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("lit_reset_state", int'(state), 0);
        chk("lit_reset_serve", int'(serve_dir), 1);
        chk("lit_reset_ball_reset", int'(ball_reset), 1);

        @(negedge clk); rst = 1'b0;
        repeat (3) cyc(1'b0, 500, 1'b1);
        chk("lit_held_button_no_start", int'(state), 0);
        cyc(1'b0, 500, 1'b0);
        cyc(1'b0, 500, 1'b1);
        chk("lit_start_state", int'(state), 1);
        chk("lit_start_serve", int'(serve_dir), 1);

        cyc(1'b0, 29, 1'b1);
        chk("lit_no_tick_no_point", int'(state), 1);
        cyc(1'b1, 29, 1'b1);
        chk("lit_left_p2_point", int'(p2_point), 1);
        chk("lit_left_state", int'(state), 2);
        chk("lit_left_serve", int'(serve_dir), 0);
        chk("lit_left_ball_reset", int'(ball_reset), 1);
        player1_score = 4'd3; player2_score = 4'd2;
        cyc(1'b0, 500, 1'b1);
        chk("lit_p2_pulse_one_cycle", int'(p2_point), 0);
        pause_ticks(59);
        chk("lit_pause_tick59", int'(state), 2);
        pause_ticks(1);
        chk("lit_pause_tick60", int'(state), 1);

        cyc(1'b1, 972, 1'b1);
        chk("lit_right_edge_no_point", int'(p1_point), 0);
        cyc(1'b1, 973, 1'b1);
        chk("lit_right_p1_point", int'(p1_point), 1);
        chk("lit_right_serve", int'(serve_dir), 1);
        player1_score = 4'd9;
        pause_ticks(60);
        chk("lit_game_over_state", int'(state), 3);
        chk("lit_game_over_winner", int'(winner), 1);

        cyc(1'b0, 500, 1'b0);
        cyc(1'b0, 500, 1'b1);
        chk("lit_menu_after_over", int'(state), 0);
        chk("lit_menu_winner_clear", int'(winner), 0);
        player1_score = 4'd0; player2_score = 4'd0;
        cyc(1'b0, 500, 1'b0);
        cyc(1'b1, 10, 1'b1);
        chk("lit_tick_with_start_state", int'(state), 1);
        chk("lit_tick_with_start_no_point", int'(p2_point), 0);
        cyc(1'b1, 10, 1'b1);
        chk("lit_next_tick_point", int'(p2_point), 1);

        pause_ticks(30);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("lit_async_state", int'(state), 0);
        chk("lit_async_serve", int'(serve_dir), 1);
        chk("lit_async_ball_reset", int'(ball_reset), 1);
        chk("lit_async_points", int'(p1_point) + int'(p2_point), 0);
        @(negedge clk); rst = 1'b0;
        cyc(1'b0, 500, 1'b1);
        chk("lit_after_reset_state", int'(state), 0);
        cyc(1'b0, 500, 1'b0);
        cyc(1'b0, 500, 1'b1);
        cyc(1'b1, 1000, 1'b1);
        chk("lit_restart_p1_point", int'(p1_point), 1);
        player2_score = 4'd9;
        pause_ticks(59);
        chk("lit_fresh_pause_tick59", int'(state), 2);
        pause_ticks(1);
        chk("lit_p2_wins_state", int'(state), 3);
        chk("lit_p2_wins_winner", int'(winner), 2);
        cyc(1'b0, 500, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
